// File: rtl/upsampler_v_fp.sv
// -----------------------------------------------------------------------------
// upsampler_v_fp
//
// 2x vertical polyphase upsampler for a raster stream of floating-point
// pixels (1 sign, EXP_WIDTH exponent, FRAC_WIDTH fraction bits).
// Each output pixel is 0.75*near_row + 0.25*far_row. The frame is handled
// as follows:
//   - Input row 0 produces output row 0.
//   - Each later input row r produces output rows 2r-1 and 2r.
//   - The last input row also produces output row 2H-1.
//
// Handshake: an input beat transfers on a rising edge where valid_i and
// ready_o are both high. The input is accepted only while the FSM is in
// LOAD. The output side has no backpressure: valid_o qualifies data_o,
// col_o and row_o for exactly one cycle per beat.
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   data_i        input pixel (raster order)
//   valid_i       data_i valid
//   ready_o       block accepts data_i this cycle
//   data_o        upsampled pixel
//   col_o, row_o  output coordinates of data_o
//   valid_o       output beat valid
//   frame_done_o  pulse with the last output beat of a frame
//   dbg_state_o   current FSM state encoding (observability only)
//
// Build option: define UPSAMPLER_V_ZERO_EDGE_EN so that out-of-image taps
// are +0.0. By default, the nearest row is replicated instead.
//
// Arithmetic notes:
//   - Subnormal operands and underflowing results flush to zero.
//   - Inf/NaN operands propagate as an exponent-all-ones result.
//   - Overflow saturates to infinity.
//   - Each product and the final sum are rounded to nearest even.
//   - The multiply/add core has a latency of 2 cycles from tap issue to
//     valid_o.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module upsampler_v_fp #(
  parameter int EXP_WIDTH  = 5,
  parameter int FRAC_WIDTH = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int FP_W = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [FP_W-1:0] data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [FP_W-1:0] data_o,
  output logic [15:0]     col_o,
  output logic [15:0]     row_o,
  output logic            valid_o,
  output logic            frame_done_o,
  output logic [2:0]      dbg_state_o
);

  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int RW   = $clog2(2 * IMG_HEIGHT);
  localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EMAX = (1 << EXP_WIDTH) - 1;
  localparam int PW   = 2 * FRAC_WIDTH + 2;  // significand product width
  localparam int GW   = FRAC_WIDTH + 4;      // hidden + fraction + guard/round/sticky
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  // Kernel taps: 0.75 = 1.1b * 2^-1, 0.25 = 1.0b * 2^-2.
  localparam logic [FP_W-1:0] K_NEAR =
    {1'b0, EXP_WIDTH'(BIAS - 1), 1'b1, {(FRAC_WIDTH-1){1'b0}}};
  localparam logic [FP_W-1:0] K_FAR =
    {1'b0, EXP_WIDTH'(BIAS - 2), {FRAC_WIDTH{1'b0}}};

  // ---------------------------------------------------------------------------
  // Floating-point helpers
  // ---------------------------------------------------------------------------
  function automatic logic [FP_W-1:0] round_pack(input logic sign, input int e_in,
                                                 input logic [FRAC_WIDTH:0] mant_in,
                                                 input logic guard, input logic sticky);
    logic [FRAC_WIDTH+1:0] m1;
    logic [FRAC_WIDTH:0]   mant;
    int                    e;
    mant = mant_in;
    e    = e_in;
    m1   = '0;
    if (guard && (sticky || mant[0])) begin
      m1 = {1'b0, mant} + 1'b1;
      // Rounding carried out of the significand: renormalise.
      if (m1[FRAC_WIDTH+1]) begin
        mant = m1[FRAC_WIDTH+1:1];
        e    = e + 1;
      end else begin
        mant = m1[FRAC_WIDTH:0];
      end
    end
    if (e >= EMAX) return {sign, EXP_ONES, {FRAC_WIDTH{1'b0}}};
    if (e <= 0)    return {sign, {(FP_W-1){1'b0}}};
    return {sign, e[EXP_WIDTH-1:0], mant[FRAC_WIDTH-1:0]};
  endfunction

  function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic                 sign;
    logic [EXP_WIDTH-1:0] ea, eb;
    logic [FRAC_WIDTH:0]  ma, mb, mant;
    logic [PW-1:0]        prod;
    logic                 guard, sticky;
    int                   e;
    sign = a[FP_W-1] ^ b[FP_W-1];
    ea   = a[FP_W-2:FRAC_WIDTH];
    eb   = b[FP_W-2:FRAC_WIDTH];
    if (ea == EXP_ONES || eb == EXP_ONES) return {sign, EXP_ONES, {FRAC_WIDTH{1'b0}}};
    if (ea == '0 || eb == '0)             return {sign, {(FP_W-1){1'b0}}};
    ma   = {1'b1, a[FRAC_WIDTH-1:0]};
    mb   = {1'b1, b[FRAC_WIDTH-1:0]};
    prod = PW'(ma) * PW'(mb);
    e    = int'(ea) + int'(eb) - BIAS;
    // Product of two [1,2) significands lies in [1,4).
    if (prod[PW-1]) begin
      mant   = prod[PW-1:FRAC_WIDTH+1];
      guard  = prod[FRAC_WIDTH];
      sticky = |prod[FRAC_WIDTH-1:0];
      e      = e + 1;
    end else begin
      mant   = prod[PW-2:FRAC_WIDTH];
      guard  = prod[FRAC_WIDTH-1];
      sticky = |prod[FRAC_WIDTH-2:0];
    end
    return round_pack(sign, e, mant, guard, sticky);
  endfunction

  function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [FP_W-1:0]      x, y;
    logic [EXP_WIDTH-1:0] ea, eb;
    logic [GW-1:0]        mx, my, mask;
    logic [GW:0]          s;
    logic                 lost;
    int                   d, e;
    ea = a[FP_W-2:FRAC_WIDTH];
    eb = b[FP_W-2:FRAC_WIDTH];
    if (ea == EXP_ONES) return a;
    if (eb == EXP_ONES) return b;
    if (ea == '0) return (eb == '0) ? {a[FP_W-1] & b[FP_W-1], {(FP_W-1){1'b0}}} : b;
    if (eb == '0) return a;
    // x carries the larger magnitude so the aligned difference never goes negative.
    if (a[FP_W-2:0] >= b[FP_W-2:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    mx = {1'b1, x[FRAC_WIDTH-1:0], 3'b000};
    my = {1'b1, y[FRAC_WIDTH-1:0], 3'b000};
    d  = int'(x[FP_W-2:FRAC_WIDTH]) - int'(y[FP_W-2:FRAC_WIDTH]);
    e  = int'(x[FP_W-2:FRAC_WIDTH]);
    if (d >= GW) begin
      my = {{(GW-1){1'b0}}, 1'b1};
    end else begin
      mask = (GW'(1) << d) - GW'(1);
      lost = |(my & mask);
      my   = (my >> d) | {{(GW-1){1'b0}}, lost};
    end
    if (x[FP_W-1] == y[FP_W-1]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[GW]) begin
        s = {1'b0, s[GW:2], s[1] | s[0]};
        e = e + 1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      if (s == '0) return '0;
      for (int i = 0; i < GW; i++) begin
        if (!s[GW-1]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    return round_pack(x[FP_W-1], e, s[GW-1:3], s[2], |s[1:0]);
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_LOAD       = 3'd0,
    S_EMIT_FIRST = 3'd1,
    S_EMIT_LO    = 3'd2,
    S_EMIT_HI    = 3'd3,
    S_EMIT_LAST  = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   col_cnt;
  logic [RW-1:0]   row_in;   // index of the input row being loaded / last loaded
  logic [RW-1:0]   out_row;  // output row currently being issued
  logic            wr_sel;   // line buffer that holds (or receives) the current row
  logic            col_last;
  logic            row_last;

  logic [FP_W-1:0] line_buf [0:1][0:IMG_WIDTH-1];

  assign col_last    = (col_cnt == CW'(IMG_WIDTH - 1));
  assign row_last    = (row_in == RW'(IMG_HEIGHT - 1));
  assign ready_o     = (state == S_LOAD);
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_LOAD;
      col_cnt <= '0;
      row_in  <= '0;
      out_row <= '0;
      wr_sel  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (valid_i) begin
            if (col_last) begin
              col_cnt <= '0;
              state   <= (row_in == '0) ? S_EMIT_FIRST : S_EMIT_LO;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        default: begin
          // Every emit state issues one tap pair per cycle for a full row.
          if (col_last) begin
            col_cnt <= '0;
            out_row <= out_row + 1'b1;
            case (state)
              S_EMIT_FIRST: begin
                state  <= S_LOAD;
                row_in <= row_in + 1'b1;
                wr_sel <= ~wr_sel;
              end
              S_EMIT_LO: state <= S_EMIT_HI;
              S_EMIT_HI: begin
                if (row_last) begin
                  state <= S_EMIT_LAST;
                end else begin
                  state  <= S_LOAD;
                  row_in <= row_in + 1'b1;
                  wr_sel <= ~wr_sel;
                end
              end
              default: begin
                // End of frame: the next accepted beat is row 0 of a new frame.
                state   <= S_LOAD;
                row_in  <= '0;
                out_row <= '0;
                wr_sel  <= ~wr_sel;
              end
            endcase
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Line buffers carry no reset; a mid-frame reset simply restarts loading.
  always_ff @(posedge clk_i) begin
    if (state == S_LOAD && valid_i) line_buf[wr_sel][col_cnt] <= data_i;
  end

  // ---------------------------------------------------------------------------
  // Tap selection (near tap weighted 0.75, far tap weighted 0.25)
  // ---------------------------------------------------------------------------
  logic [FP_W-1:0] cur_px, prev_px, edge_px, tap_near, tap_far;
  logic            issue_valid, issue_done;

  assign cur_px  = line_buf[wr_sel][col_cnt];
  assign prev_px = line_buf[~wr_sel][col_cnt];
`ifdef UPSAMPLER_V_ZERO_EDGE_EN
  assign edge_px = '0;
`else
  assign edge_px = cur_px;
`endif
  assign issue_valid = (state != S_LOAD);
  assign issue_done  = (state == S_EMIT_LAST) && col_last;

  always_comb begin
    tap_near = cur_px;
    tap_far  = edge_px;
    case (state)
      S_EMIT_LO: begin
        tap_near = prev_px;
        tap_far  = cur_px;
      end
      S_EMIT_HI: begin
        tap_near = cur_px;
        tap_far  = prev_px;
      end
      default: begin
        tap_near = cur_px;
        tap_far  = edge_px;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Two-stage multiply/add core with coordinate sideband
  // ---------------------------------------------------------------------------
  logic            s1_valid, s1_done;
  logic [CW-1:0]   s1_col;
  logic [RW-1:0]   s1_row;
  logic [FP_W-1:0] s1_p_near, s1_p_far;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_done   <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_p_near <= '0;
      s1_p_far  <= '0;
    end else begin
      s1_valid  <= issue_valid;
      s1_done   <= issue_done;
      s1_col    <= col_cnt;
      s1_row    <= out_row;
      s1_p_near <= fp_mul(tap_near, K_NEAR);
      s1_p_far  <= fp_mul(tap_far, K_FAR);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      data_o       <= '0;
      col_o        <= '0;
      row_o        <= '0;
    end else begin
      valid_o      <= s1_valid;
      frame_done_o <= s1_done;
      if (s1_valid) begin
        data_o <= fp_add(s1_p_near, s1_p_far);
        col_o  <= 16'(s1_col);
        row_o  <= 16'(s1_row);
      end
    end
  end

endmodule

// File: tb/tb_upsampler_v_fp.sv
// -----------------------------------------------------------------------------
// tb_upsampler_v_fp
//
// Directed test of upsampler_v_fp with a 4x2 input frame (FP16).
//
// Expected output beats are queued by the driver as each input row
// completes. A negedge monitor pops and compares every valid_o beat,
// checking {frame_done, row, col, data}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_upsampler_v_fp;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int FP_W  = 16;
  localparam int EXP_W = 1 + 16 + 16 + FP_W;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [FP_W-1:0] data_i = '0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [FP_W-1:0] data_o;
  logic [15:0]     col_o, row_o;
  logic            valid_o, frame_done_o;
  logic [2:0]      dbg_state_o;

  upsampler_v_fp #(
    .EXP_WIDTH (5),
    .FRAC_WIDTH(10),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .col_o       (col_o),
    .row_o       (row_o),
    .valid_o     (valid_o),
    .frame_done_o(frame_done_o),
    .dbg_state_o (dbg_state_o)
  );

  // Scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int fd_seen  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_i && valid_o) begin
      if (frame_done_o) fd_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", {frame_done_o, row_o, col_o, data_o}, 64'd0);
      end else begin
        check("output_beat", {frame_done_o, row_o, col_o, data_o}, exp_q.pop_front());
      end
    end
    if (!rst_i && frame_done_o && !valid_o) check("frame_done_without_valid", 64'd1, 64'd0);
  end

  // Driver tasks
  task automatic push_row(input int row, input logic [FP_W-1:0] val);
    for (int c = 0; c < W; c++)
      exp_q.push_back({(row == 2*H-1 && c == W-1), 16'(row), 16'(c), val});
  endtask

  task automatic drive_row(input logic [FP_W-1:0] val, input bit rnd, input bit hold);
    int t;
    for (int c = 0; c < W; c++) begin
      if (rnd && $urandom_range(0, 1) == 1) begin
        valid_i = 1'b0;
        data_i  = 16'h7777;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      valid_i = 1'b1;
      data_i  = val;
      t = 0;
      while (!ready_o && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      check("ready_wait", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
    end
    // With hold set, keep presenting junk that must be ignored while busy.
    if (hold) data_i = 16'h7bff;
    else begin
      valid_i = 1'b0;
      data_i  = '0;
    end
  endtask

  task automatic emit_window(input int n);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (ready_o) hi++;
      @(posedge clk); #1;
    end
    check("ready_low_in_emit", 64'(hi), 64'd0);
    check("ready_after_emit", 64'(ready_o), 64'd1);
  endtask

  task automatic drive_frame(input logic [FP_W-1:0] in0, input logic [FP_W-1:0] in1,
                             input logic [FP_W-1:0] e0, input logic [FP_W-1:0] e1,
                             input logic [FP_W-1:0] e2, input logic [FP_W-1:0] e3,
                             input bit rnd, input bit hold);
    drive_row(in0, rnd, hold);
    push_row(0, e0);
    emit_window(W);
    drive_row(in1, rnd, hold);
    push_row(1, e1);
    push_row(2, e2);
    push_row(3, e3);
    emit_window(3*W);
  endtask

  // Hand-computed expected rows
`ifdef UPSAMPLER_V_ZERO_EDGE_EN
  localparam logic [15:0] ONES_R0 = 16'h3A00, ONES_R3 = 16'h3A00;
  localparam logic [15:0] STEP_R3 = 16'h4200;
`else
  localparam logic [15:0] ONES_R0 = 16'h3C00, ONES_R3 = 16'h3C00;
  localparam logic [15:0] STEP_R3 = 16'h4400;
`endif

  initial begin
    int vhi;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_o", 64'(valid_o), 64'd0);
    check("reset_frame_done_o", 64'(frame_done_o), 64'd0);
    check("reset_data_o", 64'(data_o), 64'd0);
    check("reset_col_o", 64'(col_o), 64'd0);
    check("reset_row_o", 64'(row_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check("ready_after_reset", 64'(ready_o), 64'd1);
    @(posedge clk); #1;

    // All-ones frame
    drive_frame(16'h3C00, 16'h3C00, ONES_R0, 16'h3C00, 16'h3C00, ONES_R3, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    // Step 0 -> 4.0
    drive_frame(16'h0000, 16'h4400, 16'h0000, 16'h3C00, 16'h4200, STEP_R3, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    // Same step frame with valid_i gaps
    drive_frame(16'h0000, 16'h4400, 16'h0000, 16'h3C00, 16'h4200, STEP_R3, 1'b1, 1'b0);
    repeat (4) @(posedge clk); #1;

    // Reset while in EMIT_LO: only output row 0 may appear
    drive_row(16'h3C00, 1'b0, 1'b0);
    push_row(0, ONES_R0);
    emit_window(W);
    drive_row(16'h4400, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    check("midreset_valid_o", 64'(valid_o), 64'd0);
    check("midreset_data_o", 64'(data_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("ready_after_midreset", 64'(ready_o), 64'd1);
    vhi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_o) vhi++;
    end
    check("no_valid_after_midreset", 64'(vhi), 64'd0);
    @(posedge clk); #1;
    drive_frame(16'h0000, 16'h4400, 16'h0000, 16'h3C00, 16'h4200, STEP_R3, 1'b0, 1'b0);

    // Back-to-back frames with valid_i held high
    drive_frame(16'h3C00, 16'h3C00, ONES_R0, 16'h3C00, 16'h3C00, ONES_R3, 1'b0, 1'b1);
    drive_frame(16'h0000, 16'h4400, 16'h0000, 16'h3C00, 16'h4200, STEP_R3, 1'b0, 1'b1);
    valid_i = 1'b0;
    data_i  = '0;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("frame_done_count", 64'(fd_seen), 64'd6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
